fetch_align_queue: RTL and testbench

Instruction-fetch front end that feeds the IF/ID pipeline register of the RV32IC core. It issues word-aligned fetch requests to instruction memory and buffers the returned halfwords. It presents one aligned instruction per handshake, either 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary. On a redirect (branch, jump, MRET, interrupt) it flushes its buffer and discards stale in-flight responses.

---
 rtl/fetch_align_queue_if.sv | 31 +++
 rtl/fetch_align_queue.sv | 134 +++++++++++++
 tb/tb_fetch_align_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_align_queue_if.sv
// Signal bundle between the fetch front end, instruction memory and the decode stage.
// master: fetch_align_queue. slave: memory plus decode (or a testbench standing in for them).
interface fetch_align_queue_if;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_req_addr_o;
   logic        mem_rsp_valid_i;
   logic [31:0] mem_rsp_data_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_compressed_o;
   logic        drop_pending_o;

   // valid/ready: a transfer happens on a rising clock edge where valid and ready are both 1.
   // Once raised, valid stays up and its payload holds until that edge, unless a redirect flushes it.
   modport master (
      output mem_req_valid_o, mem_req_addr_o,
      input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
      output instr_valid_o, instr_o, instr_pc_o, instr_compressed_o, drop_pending_o,
      input  instr_ready_i
   );

   modport slave (
      input  mem_req_valid_o, mem_req_addr_o,
      output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
      input  instr_valid_o, instr_o, instr_pc_o, instr_compressed_o, drop_pending_o,
      output instr_ready_i
   );
endinterface

// File: rtl/fetch_align_queue.sv
// RV32IC fetch front end: word fetches into a halfword FIFO, aligned 16/32-bit instruction out,
// redirect flushes the buffer and drops responses to requests issued before it.
module fetch_align_queue #(
   parameter int unsigned DEPTH_HW  = 8,
   parameter int unsigned MAX_OUTST = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                clk_i,
   input  logic                rst,
   input  logic                redirect_i,
   input  logic [31:0]         redirect_pc_i,
   fetch_align_queue_if.master bus
);
   localparam int PW = $clog2(DEPTH_HW);
   localparam int CW = PW + 1;

   logic [15:0]   buf_q [DEPTH_HW];
   logic [15:0]   buf_d [DEPTH_HW];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [1:0]    outst_q, outst_d;
   logic [1:0]    drop_q, drop_d;
   logic [31:0]   fetch_addr_q, fetch_addr_d;
   logic [31:0]   out_pc_q, out_pc_d;
   logic          skip_q, skip_d;

   logic [PW-1:0] rd_ptr_p1, wr_ptr_p1;
   logic [15:0]   h0, h1;
   logic          head_is32;
   logic          instr_valid;
   logic          req_valid;
   logic          req_fire;
   logic [1:0]    pop_n, wr_n;
   int            space;

   assign rd_ptr_p1   = rd_ptr_q + PW'(1);
   assign wr_ptr_p1   = wr_ptr_q + PW'(1);
   assign h0          = buf_q[rd_ptr_q];
   assign h1          = buf_q[rd_ptr_p1];
   assign head_is32   = (h0[1:0] == 2'b11);
   assign instr_valid = head_is32 ? (count_q >= CW'(2)) : (count_q != '0);

   // Every in-flight word already owns two free slots, so a response can never overflow the FIFO.
   assign space     = int'(DEPTH_HW) - int'(count_q) - 2 * int'(outst_q);
   assign req_valid = rst && !redirect_i && (int'(outst_q) < int'(MAX_OUTST)) && (space >= 2);
   assign req_fire  = req_valid && bus.mem_req_ready_i;

   assign bus.mem_req_valid_o    = req_valid;
   assign bus.mem_req_addr_o     = fetch_addr_q;
   assign bus.instr_valid_o      = instr_valid;
   assign bus.instr_o            = !instr_valid ? 32'h0 :
                                   head_is32    ? {h1, h0} : {16'h0, h0};
   assign bus.instr_pc_o         = out_pc_q;
   assign bus.instr_compressed_o = instr_valid && !head_is32;
   assign bus.drop_pending_o     = (drop_q != 2'd0);

   always_comb begin
      buf_d        = buf_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      outst_d      = outst_q;
      drop_d       = drop_q;
      fetch_addr_d = fetch_addr_q;
      out_pc_d     = out_pc_q;
      skip_d       = skip_q;
      pop_n        = 2'd0;
      wr_n         = 2'd0;
      if (redirect_i) begin
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
         out_pc_d     = redirect_pc_i & 32'hFFFF_FFFE;
         fetch_addr_d = redirect_pc_i & 32'hFFFF_FFFC;
         skip_d       = redirect_pc_i[1];
         // A response arriving now is thrown away; everything still in flight becomes stale.
         outst_d      = outst_q - {1'b0, bus.mem_rsp_valid_i};
         drop_d       = outst_q - {1'b0, bus.mem_rsp_valid_i};
      end else begin
         if (instr_valid && bus.instr_ready_i) begin
            pop_n    = head_is32 ? 2'd2 : 2'd1;
            out_pc_d = out_pc_q + (head_is32 ? 32'd4 : 32'd2);
         end
         if (req_fire) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
         end
         outst_d = outst_q + {1'b0, req_fire} - {1'b0, bus.mem_rsp_valid_i};
         if (bus.mem_rsp_valid_i) begin
            if (drop_q != 2'd0) begin
               drop_d = drop_q - 2'd1;
            end else if (skip_q) begin
               // Target was the upper halfword of this word: keep only [31:16].
               buf_d[wr_ptr_q] = bus.mem_rsp_data_i[31:16];
               wr_n            = 2'd1;
               skip_d          = 1'b0;
            end else begin
               buf_d[wr_ptr_q]  = bus.mem_rsp_data_i[15:0];
               buf_d[wr_ptr_p1] = bus.mem_rsp_data_i[31:16];
               wr_n             = 2'd2;
            end
         end
         rd_ptr_d = rd_ptr_q + PW'(pop_n);
         wr_ptr_d = wr_ptr_q + PW'(wr_n);
         count_d  = count_q + CW'(wr_n) - CW'(pop_n);
      end
   end

   always_ff @(posedge clk_i or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH_HW); i++) begin
            buf_q[i] <= 16'h0;
         end
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         outst_q      <= 2'd0;
         drop_q       <= 2'd0;
         fetch_addr_q <= {RESET_PC[31:2], 2'b00};
         out_pc_q     <= RESET_PC;
         skip_q       <= RESET_PC[1];
      end else begin
         buf_q        <= buf_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         outst_q      <= outst_d;
         drop_q       <= drop_d;
         fetch_addr_q <= fetch_addr_d;
         out_pc_q     <= out_pc_d;
         skip_q       <= skip_d;
      end
   end
endmodule

// File: tb/tb_fetch_align_queue.sv
// Directed bench for fetch_align_queue: a halfword-queue reference model checked every cycle,
// plus hand-computed instruction/PC expectations for each scenario.
module tb_fetch_align_queue;
   localparam int          DEPTH_HW  = 8;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   fetch_align_queue_if bus ();

   fetch_align_queue #(
      .DEPTH_HW (DEPTH_HW),
      .MAX_OUTST(MAX_OUTST),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk_i        (clk),
      .rst          (rst),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .bus          (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        comp;
   } acc_t;

   int          n_chk;
   int          n_pass;
   logic        rsp_en;
   logic        rdy_toggle;
   logic        ir_toggle;
   logic [31:0] pend_q[$];
   logic [31:0] req_log[$];
   acc_t        acc_q[$];
   logic [31:0] mem [logic [31:0]];

   // reference model
   logic [15:0] hq[$];
   logic [31:0] m_out_pc;
   logic [31:0] m_fetch;
   int          m_outst;
   int          m_drop;
   logic        m_skip;
   logic        e_valid;
   logic        e_is32;
   logic        e_req;
   logic [31:0] e_instr;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
   endfunction

   function automatic logic [15:0] def_hw(logic [31:0] a);
      return {a[15:2], 2'b01};
   endfunction

   function automatic logic [31:0] mem_rd(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {def_hw(a), def_hw(a)};
   endfunction

   function automatic void model_reset();
      logic [31:0] rpc;
      rpc      = RESET_PC;
      hq.delete();
      m_out_pc = rpc;
      m_fetch  = rpc & ~32'h3;
      m_skip   = rpc[1];
      m_outst  = 0;
      m_drop   = 0;
   endfunction

   function automatic void check_acc(int i, logic [31:0] instr, logic [31:0] pc, logic comp);
      if (acc_q.size() > i) begin
         chk($sformatf("acc%0d_instr", i), acc_q[i].instr, instr);
         chk($sformatf("acc%0d_pc", i), acc_q[i].pc, pc);
         chk($sformatf("acc%0d_comp", i), 32'(acc_q[i].comp), 32'(comp));
      end else begin
         chk($sformatf("acc%0d_present", i), 32'(acc_q.size()), 32'(i + 1));
      end
   endfunction

   function automatic void check_req(int i, logic [31:0] addr);
      if (req_log.size() > i) chk($sformatf("req%0d_addr", i), req_log[i], addr);
      else chk($sformatf("req%0d_present", i), 32'(req_log.size()), 32'(i + 1));
   endfunction

   // ---------------- compare process + memory capture ----------------
   always @(negedge clk) begin
      if (!rst) begin
         model_reset();
         chk("rst_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
         chk("rst_req_addr", bus.mem_req_addr_o, RESET_PC & ~32'h3);
         chk("rst_instr_valid", 32'(bus.instr_valid_o), 32'd0);
         chk("rst_drop_pending", 32'(bus.drop_pending_o), 32'd0);
      end else begin
         e_is32  = 1'b0;
         e_valid = 1'b0;
         e_instr = 32'h0;
         if (hq.size() > 0) begin
            e_is32 = (hq[0][1:0] == 2'b11);
            if (!e_is32) begin
               e_valid = 1'b1;
               e_instr = {16'h0, hq[0]};
            end else if (hq.size() >= 2) begin
               e_valid = 1'b1;
               e_instr = {hq[1], hq[0]};
            end
         end
         e_req = !redirect_i && (m_outst < MAX_OUTST) &&
                 ((DEPTH_HW - hq.size() - 2 * m_outst) >= 2);

         chk("req_valid", 32'(bus.mem_req_valid_o), 32'(e_req));
         chk("req_addr", bus.mem_req_addr_o, m_fetch);
         chk("instr_valid", 32'(bus.instr_valid_o), 32'(e_valid));
         chk("instr_pc", bus.instr_pc_o, m_out_pc);
         chk("drop_pending", 32'(bus.drop_pending_o), 32'(m_drop != 0));
         if (e_valid) begin
            chk("instr", bus.instr_o, e_instr);
            chk("instr_comp", 32'(bus.instr_compressed_o), 32'(!e_is32));
         end

         if (bus.instr_valid_o && bus.instr_ready_i && !redirect_i)
            acc_q.push_back('{bus.instr_o, bus.instr_pc_o, bus.instr_compressed_o});
         if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
            pend_q.push_back(bus.mem_req_addr_o);
            req_log.push_back(bus.mem_req_addr_o);
         end

         if (redirect_i) begin
            hq.delete();
            m_out_pc = redirect_pc_i & ~32'h1;
            m_fetch  = redirect_pc_i & ~32'h3;
            m_skip   = redirect_pc_i[1];
            m_outst  = m_outst - (bus.mem_rsp_valid_i ? 1 : 0);
            m_drop   = m_outst;
         end else begin
            if (e_valid && bus.instr_ready_i) begin
               void'(hq.pop_front());
               if (e_is32) void'(hq.pop_front());
               m_out_pc = m_out_pc + (e_is32 ? 32'd4 : 32'd2);
            end
            if (e_req && bus.mem_req_ready_i) begin
               m_fetch = m_fetch + 32'd4;
               m_outst = m_outst + 1;
            end
            if (bus.mem_rsp_valid_i) begin
               m_outst = m_outst - 1;
               if (m_drop > 0) begin
                  m_drop = m_drop - 1;
               end else if (m_skip) begin
                  hq.push_back(bus.mem_rsp_data_i[31:16]);
                  m_skip = 1'b0;
               end else begin
                  hq.push_back(bus.mem_rsp_data_i[15:0]);
                  hq.push_back(bus.mem_rsp_data_i[31:16]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
      if (rdy_toggle) bus.mem_req_ready_i = !bus.mem_req_ready_i;
      if (ir_toggle) bus.instr_ready_i = !bus.instr_ready_i;
      if (rsp_en && pend_q.size() > 0) begin
         bus.mem_rsp_valid_i = 1'b1;
         bus.mem_rsp_data_i  = mem_rd(pend_q.pop_front());
      end else begin
         bus.mem_rsp_valid_i = 1'b0;
         bus.mem_rsp_data_i  = 32'h0;
      end
   endtask

   task automatic do_reset();
      rst                 = 1'b0;
      redirect_i          = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      pend_q.delete();
      cycle();
      cycle();
      pend_q.delete();
      acc_q.delete();
      req_log.delete();
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed scenarios ----------------
   initial begin
      n_chk = 0; n_pass = 0;
      rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      bus.mem_req_ready_i = 1'b1; bus.mem_rsp_valid_i = 1'b0; bus.mem_rsp_data_i = 32'h0;
      bus.instr_ready_i = 1'b1;
      rsp_en = 1'b1; rdy_toggle = 1'b0; ir_toggle = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("reset_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
      chk("reset_req_addr", bus.mem_req_addr_o, 32'h0);
      chk("reset_instr_valid", 32'(bus.instr_valid_o), 32'd0);
      chk("reset_instr", bus.instr_o, 32'h0);
      chk("reset_pc", bus.instr_pc_o, 32'h0);
      chk("reset_comp", 32'(bus.instr_compressed_o), 32'd0);
      chk("reset_drop", 32'(bus.drop_pending_o), 32'd0);

      // basic fetch: addi then two compressed halfwords
      mem.delete();
      mem[32'h0] = 32'h00A0_0093;
      mem[32'h4] = 32'h4501_4581;
      do_reset();
      repeat (10) cycle();
      check_req(0, 32'h0);
      check_acc(0, 32'h00A0_0093, 32'h0, 1'b0);
      check_acc(1, 32'h0000_4581, 32'h4, 1'b1);
      check_acc(2, 32'h0000_4501, 32'h6, 1'b1);

      // 32-bit instruction straddling a word boundary
      mem.delete();
      mem[32'h0] = 32'h0093_4581;
      mem[32'h4] = 32'h1234_00A0;
      do_reset();
      cycle();
      rsp_en = 1'b0;
      repeat (4) cycle();
      #2;
      chk("straddle_wait_valid", 32'(bus.instr_valid_o), 32'd0);
      chk("straddle_wait_pc", bus.instr_pc_o, 32'h2);
      rsp_en = 1'b1;
      repeat (6) cycle();
      check_acc(0, 32'h0000_4581, 32'h0, 1'b1);
      check_acc(1, 32'h00A0_0093, 32'h2, 1'b0);

      // redirect to 0x102 with two requests outstanding
      mem.delete();
      mem[32'h100] = 32'h8082_4501;
      do_reset();
      rsp_en = 1'b0;
      cycle();
      cycle();
      redirect_i = 1'b1; redirect_pc_i = 32'h102;
      acc_q.delete(); req_log.delete();
      cycle();
      redirect_i = 1'b0;
      #2;
      chk("redir_drop_pending0", 32'(bus.drop_pending_o), 32'd1);
      chk("redir_no_req", 32'(bus.mem_req_valid_o), 32'd0);
      rsp_en = 1'b1;
      cycle(); #2;
      chk("redir_drop_pending1", 32'(bus.drop_pending_o), 32'd1);
      cycle(); #2;
      chk("redir_drop_pending2", 32'(bus.drop_pending_o), 32'd1);
      cycle(); #2;
      chk("redir_drop_done", 32'(bus.drop_pending_o), 32'd0);
      repeat (6) cycle();
      check_req(0, 32'h100);
      check_acc(0, 32'h0000_8082, 32'h102, 1'b1);

      // redirect in the same cycle as a response, decode ready
      mem.delete();
      do_reset();
      repeat (4) cycle();
      for (int g = 0; g < 8 && !bus.mem_rsp_valid_i; g++) cycle();
      chk("redir_rsp_present", 32'(bus.mem_rsp_valid_i), 32'd1);
      redirect_i = 1'b1; redirect_pc_i = 32'h201;
      acc_q.delete();
      cycle();
      redirect_i = 1'b0;
      #2;
      chk("redir_same_pc", bus.instr_pc_o, 32'h200);
      chk("redir_same_empty", 32'(bus.instr_valid_o), 32'd0);
      repeat (8) cycle();
      check_acc(0, 32'h0000_0201, 32'h200, 1'b1);

      // back-pressure: decode stalls, buffer fills, fetch stops, then drains in order
      mem.delete();
      bus.instr_ready_i = 1'b0;
      do_reset();
      repeat (20) cycle();
      #2;
      chk("bp_words_accepted", 32'(req_log.size()), 32'd4);
      chk("bp_req_stopped", 32'(bus.mem_req_valid_o), 32'd0);
      chk("bp_head_pc", bus.instr_pc_o, 32'h0);
      bus.instr_ready_i = 1'b1;
      repeat (30) cycle();
      for (int k = 0; k < 16; k++)
         check_acc(k, {16'h0, def_hw(32'(2 * k) & ~32'h3)}, 32'(2 * k), 1'b1);

      // asynchronous reset in the middle of an outstanding request
      do_reset();
      rsp_en = 1'b0;
      cycle();
      #2;
      chk("mid_req_valid_before", 32'(bus.mem_req_valid_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_req_valid", 32'(bus.mem_req_valid_o), 32'd0);
      chk("mid_rst_req_addr", bus.mem_req_addr_o, 32'h0);
      chk("mid_rst_instr_valid", 32'(bus.instr_valid_o), 32'd0);
      chk("mid_rst_drop", 32'(bus.drop_pending_o), 32'd0);
      do_reset();
      rsp_en = 1'b1;
      repeat (8) cycle();
      check_req(0, 32'h0);
      check_acc(0, 32'h0000_0001, 32'h0, 1'b1);

      // mixed stream with memory and decode stalls toggling every cycle
      mem.delete();
      mem[32'h0] = 32'h00A0_0093;
      mem[32'h4] = 32'h0093_4581;
      mem[32'h8] = 32'h4501_00A0;
      do_reset();
      rdy_toggle = 1'b1; ir_toggle = 1'b1;
      repeat (40) cycle();
      rdy_toggle = 1'b0; ir_toggle = 1'b0;
      check_acc(0, 32'h00A0_0093, 32'h0, 1'b0);
      check_acc(1, 32'h0000_4581, 32'h4, 1'b1);
      check_acc(2, 32'h00A0_0093, 32'h6, 1'b0);
      check_acc(3, 32'h0000_4501, 32'hA, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
